// File: rtl/sprite_pkg.sv
// Shared sprite definitions: keycodes, screen size, motion FSM states and the
// per-axis clamp/wrap helper used by sprite_motion.
package sprite_pkg;

    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        BLOCKED
    } motion_state_t;

    // Folds a signed candidate coordinate back into [lo, hi]: saturate, or jump
    // to the opposite edge when wrap is set.
    function automatic logic [9:0] bound_axis(input logic signed [10:0] v,
                                              input logic signed [10:0] lo,
                                              input logic signed [10:0] hi,
                                              input logic               wrap);
        logic signed [10:0] r;
        r = v;
        if (v < lo)      r = wrap ? hi : lo;
        else if (v > hi) r = wrap ? lo : hi;
        return r[9:0];
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous vertical-sync pulse into the Clk domain and emits a
// one-cycle tick on each fresh rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] vld_q;

    // prev_q starts high and only tracks sync_q once the chain holds real
    // samples, so a frame_clk already high at reset release never ticks.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b1;
            vld_q  <= 2'b00;
        end else begin
            meta_q <= frame_clk;
            sync_q <= meta_q;
            vld_q  <= {vld_q[0], 1'b1};
            prev_q <= vld_q[1] ? sync_q : 1'b1;
        end
    end

    assign tick = sync_q & ~prev_q & vld_q[1];

endmodule

// File: rtl/sprite_motion.sv
// Sprite position engine: moves one STEP per frame tick on a keycode, reverts on
// collision. Define SPRITE_MOTION_WRAP_EN to wrap at screen edges instead of clamping.
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int STEP    = 1,
    parameter int X_START = 320,
    parameter int Y_START = 240,
    parameter int SIZE    = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       collision,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic       moving,
    output logic       blocked
);

`ifdef SPRITE_MOTION_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] X_LO   = 11'(SIZE);
    localparam logic signed [10:0] X_HI   = 11'(SCREEN_W - 1 - SIZE);
    localparam logic signed [10:0] Y_LO   = 11'(SIZE);
    localparam logic signed [10:0] Y_HI   = 11'(SCREEN_H - 1 - SIZE);

    logic               tick;
    logic [9:0]         pos_x_q, pos_y_q;
    logic [9:0]         last_x_q, last_y_q;
    logic [9:0]         pos_x_d, pos_y_d;
    logic signed [10:0] dx, dy;
    logic               is_motion;
    motion_state_t      state_q;
    logic               moving_q;
    logic               blocked_q;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        dx        = '0;
        dy        = '0;
        is_motion = 1'b0;
        case (keycode)
            KEY_RIGHT: begin dx =  STEP_S; is_motion = 1'b1; end
            KEY_LEFT:  begin dx = -STEP_S; is_motion = 1'b1; end
            KEY_DOWN:  begin dy =  STEP_S; is_motion = 1'b1; end
            KEY_UP:    begin dy = -STEP_S; is_motion = 1'b1; end
            default:   ;
        endcase
        pos_x_d = bound_axis($signed({1'b0, pos_x_q}) + dx, X_LO, X_HI, WRAP);
        pos_y_d = bound_axis($signed({1'b0, pos_y_q}) + dy, Y_LO, Y_HI, WRAP);
    end

    // Inputs are only looked at in the tick cycle; collision overrides any step.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x_q   <= 10'(X_START);
            pos_y_q   <= 10'(Y_START);
            last_x_q  <= 10'(X_START);
            last_y_q  <= 10'(Y_START);
            state_q   <= IDLE;
            moving_q  <= 1'b0;
            blocked_q <= 1'b0;
        end else if (tick) begin
            if (collision) begin
                state_q   <= BLOCKED;
                blocked_q <= 1'b1;
                if (state_q != BLOCKED) begin
                    pos_x_q  <= last_x_q;
                    pos_y_q  <= last_y_q;
                    moving_q <= (last_x_q != pos_x_q) || (last_y_q != pos_y_q);
                end else begin
                    moving_q <= 1'b0;
                end
            end else begin
                last_x_q  <= pos_x_q;
                last_y_q  <= pos_y_q;
                pos_x_q   <= pos_x_d;
                pos_y_q   <= pos_y_d;
                moving_q  <= (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
                state_q   <= is_motion ? MOVE : IDLE;
                blocked_q <= 1'b0;
            end
        end
    end

    assign PosX    = pos_x_q;
    assign PosY    = pos_y_q;
    assign moving  = moving_q;
    assign blocked = blocked_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Scoreboard bench for sprite_motion: a reference model pushes the expected
// outputs of each frame, popped and compared after the third Clk edge.
module tb_sprite_motion;

    logic       Clk       = 1'b0;
    logic       Reset_n   = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic       collision = 1'b0;
    logic [9:0] PosX, PosY;
    logic       moving, blocked;

    always #5 Clk = ~Clk;

    sprite_motion dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .collision (collision),
        .PosX      (PosX),
        .PosY      (PosY),
        .moving    (moving),
        .blocked   (blocked)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       mv;
        logic       bl;
    } obs_t;

    localparam int LO  = 4;
    localparam int XHI = 635;
    localparam int YHI = 475;
`ifdef SPRITE_MOTION_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    obs_t exp_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   m_x, m_y, m_lx, m_ly;
    bit   m_blk;

    function automatic int axis(input int v, input int hi);
        if (v < LO) return WRAP ? hi : LO;
        if (v > hi) return WRAP ? LO : hi;
        return v;
    endfunction

    function automatic obs_t cur_obs();
        return {PosX, PosY, moving, blocked};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("(x=%0d y=%0d mv=%0b bl=%0b)", o.x, o.y, o.mv, o.bl);
    endfunction

    task automatic model_reset();
        m_x = 320; m_y = 240; m_lx = 320; m_ly = 240; m_blk = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic [7:0] key, input logic coll);
        int   nx, ny;
        obs_t e;
        nx = m_x;
        ny = m_y;
        if (coll) begin
            if (!m_blk) begin nx = m_lx; ny = m_ly; end
            m_blk = 1'b1;
        end else begin
            case (key)
                8'h4F:   nx = axis(m_x + 1, XHI);
                8'h50:   nx = axis(m_x - 1, XHI);
                8'h51:   ny = axis(m_y + 1, YHI);
                8'h52:   ny = axis(m_y - 1, YHI);
                default: ;
            endcase
            m_lx  = m_x;
            m_ly  = m_y;
            m_blk = 1'b0;
        end
        e.x  = 10'(nx);
        e.y  = 10'(ny);
        e.mv = (nx != m_x) || (ny != m_y);
        e.bl = m_blk;
        m_x  = nx;
        m_y  = ny;
        exp_q.push_back(e);
    endtask

    // One frame: decoy key/collision values in every non-tick cycle, the real
    // ones only in the tick cycle. pre is sampled after edge 2, post after edge 3.
    task automatic do_frame(input logic [7:0] key, input logic coll,
                            output obs_t pre, output obs_t post);
        model_push(key, coll);
        @(negedge Clk); frame_clk = 1'b1; keycode = 8'h4F; collision = 1'b1;
        @(negedge Clk); keycode = 8'h00;
        @(negedge Clk); keycode = key; collision = coll; pre = cur_obs();
        @(posedge Clk); #1 post = cur_obs();
        @(negedge Clk); frame_clk = 1'b0; keycode = 8'h4F; collision = 1'b1;
        @(negedge Clk); keycode = 8'h00;
        @(negedge Clk); keycode = 8'h51;
        @(negedge Clk); keycode = 8'h00; collision = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge Clk); Reset_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00; collision = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset();
        obs_t want;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        want = '{10'd320, 10'd240, 1'b0, 1'b0};
        n_asserts++;
        if (cur_obs() !== want) begin
            n_fail++;
            $display("FAIL reset_state: got %s expected %s", fmt(cur_obs()), fmt(want));
        end
        Reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_single_step();
        obs_t pre, post, e, want;
        apply_reset();
        do_frame(8'h4F, 1'b0, pre, post);
        want = '{10'd320, 10'd240, 1'b0, 1'b0};
        n_asserts++;
        if (pre !== want) begin
            n_fail++;
            $display("FAIL step_before_edge3: got %s expected %s", fmt(pre), fmt(want));
        end
        e = exp_q.pop_front();
        n_asserts++;
        if (post !== e) begin
            n_fail++;
            $display("FAIL step_after_edge3: got %s expected %s", fmt(post), fmt(e));
        end
        want = '{10'd321, 10'd240, 1'b1, 1'b0};
        n_asserts++;
        if (post !== want) begin
            n_fail++;
            $display("FAIL step_321: got %s expected %s", fmt(post), fmt(want));
        end
    endtask

    task automatic test_clamp();
        obs_t pre, post, e, want;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            do_frame(8'h50, 1'b0, pre, post);
            e = exp_q.pop_front();
            n_asserts++;
            if (post !== e) begin
                n_fail++;
                $display("FAIL left_frame_%0d: got %s expected %s", i, fmt(post), fmt(e));
            end
            if (i == 315) begin
                want = '{10'd4, 10'd240, 1'b1, 1'b0};
                n_asserts++;
                if (post !== want) begin
                    n_fail++;
                    $display("FAIL left_reach_4: got %s expected %s", fmt(post), fmt(want));
                end
            end
            if (i == 316) begin
`ifdef SPRITE_MOTION_WRAP_EN
                want = '{10'd635, 10'd240, 1'b1, 1'b0};
`else
                want = '{10'd4, 10'd240, 1'b0, 1'b0};
`endif
                n_asserts++;
                if (post !== want) begin
                    n_fail++;
                    $display("FAIL left_edge: got %s expected %s", fmt(post), fmt(want));
                end
            end
        end
    endtask

    task automatic test_collision();
        obs_t pre, post, e, want;
        logic [7:0] keys [6] = '{8'h52, 8'h52, 8'h52, 8'h52, 8'h00, 8'h52};
        logic       colls[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_frame(keys[i], colls[i], pre, post);
            e = exp_q.pop_front();
            n_asserts++;
            if (post !== e) begin
                n_fail++;
                $display("FAIL collision_frame_%0d: got %s expected %s", i, fmt(post), fmt(e));
            end
            if (i == 2) begin
                n_asserts++;
                if (post.y !== 10'd239 || post.bl !== 1'b1) begin
                    n_fail++;
                    $display("FAIL collision_revert: got y=%0d bl=%0b expected y=239 bl=1",
                             post.y, post.bl);
                end
            end
        end
    endtask

    task automatic test_key_ignore();
        obs_t pre, post, e, want;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_frame(8'h51, 1'b0, pre, post);
            e = exp_q.pop_front();
            n_asserts++;
            if (post !== e) begin
                n_fail++;
                $display("FAIL toggle_frame_%0d: got %s expected %s", i, fmt(post), fmt(e));
            end
        end
        want = '{10'd320, 10'd243, 1'b1, 1'b0};
        n_asserts++;
        if (post !== want) begin
            n_fail++;
            $display("FAIL toggle_y_only: got %s expected %s", fmt(post), fmt(want));
        end
    endtask

    task automatic test_async_reset();
        obs_t pre, post, e, want;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            do_frame(8'h4F, 1'b0, pre, post);
            e = exp_q.pop_front();
            n_asserts++;
            if (post !== e) begin
                n_fail++;
                $display("FAIL move_frame_%0d: got %s expected %s", i, fmt(post), fmt(e));
            end
        end
        @(negedge Clk); frame_clk = 1'b1; keycode = 8'h4F; collision = 1'b0;
        @(posedge Clk); #2 Reset_n = 1'b0;
        #1;
        want = '{10'd320, 10'd240, 1'b0, 1'b0};
        n_asserts++;
        if (cur_obs() !== want) begin
            n_fail++;
            $display("FAIL async_reset: got %s expected %s", fmt(cur_obs()), fmt(want));
        end
        @(negedge Clk); Reset_n = 1'b1;
        model_reset();
        repeat (6) @(posedge Clk);
        #1;
        n_asserts++;
        if (cur_obs() !== want) begin
            n_fail++;
            $display("FAIL no_tick_high_release: got %s expected %s", fmt(cur_obs()), fmt(want));
        end
        @(negedge Clk); frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        do_frame(8'h4F, 1'b0, pre, post);
        e = exp_q.pop_front();
        n_asserts++;
        if (post !== e) begin
            n_fail++;
            $display("FAIL after_reset_step: got %s expected %s", fmt(post), fmt(e));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_step();
        test_clamp();
        test_collision();
        test_key_ignore();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
